// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: one byte-strobed write
// port, two independent read request/response ports and the address error flag.
interface regfile_2r1w_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_WIDTH  = 16
);
  localparam int STRB_WIDTH = MEM_WIDTH / 8;

  logic                  WrEn;
  logic [ADDR_WIDTH-1:0] WrAddr;
  logic [MEM_WIDTH-1:0]  WrData;
  logic [STRB_WIDTH-1:0] WrStrb;

  logic                  RdEnA;
  logic [ADDR_WIDTH-1:0] RdAddrA;
  logic [MEM_WIDTH-1:0]  RdDataA;
  logic                  RdValidA;

  logic                  RdEnB;
  logic [ADDR_WIDTH-1:0] RdAddrB;
  logic [MEM_WIDTH-1:0]  RdDataB;
  logic                  RdValidB;

  logic                  AddrErr;

  modport master (
    output WrEn, WrAddr, WrData, WrStrb,
    output RdEnA, RdAddrA, RdEnB, RdAddrB,
    input  RdDataA, RdValidA, RdDataB, RdValidB, AddrErr
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrStrb,
    input  RdEnA, RdAddrA, RdEnB, RdAddrB,
    output RdDataA, RdValidA, RdDataB, RdValidB, AddrErr
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with one byte-strobed write port and two registered read
// ports; same-cycle write/read to one address returns the merged word.
module regfile_2r1w #(
  parameter  int MEM_DEPTH  = 8,
  parameter  int MEM_WIDTH  = 16,
  parameter  int ADDR_WIDTH = 3,
  localparam int STRB_WIDTH = MEM_WIDTH / 8
) (
  input  logic               CLK,
  input  logic               RST,
  regfile_2r1w_if.slave      bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic                 wr_ok, rd_ok_a, rd_ok_b;
  logic                 wr_fire;
  logic                 addr_err_d;
  logic [MEM_WIDTH-1:0] wr_old;
  logic [MEM_WIDTH-1:0] wr_word;
  logic [MEM_WIDTH-1:0] rd_word_a, rd_word_b;

  // Per-lane select between incoming write data and the stored word.
  function automatic logic [MEM_WIDTH-1:0] merge_lanes(
    input logic [MEM_WIDTH-1:0]  old_word,
    input logic [MEM_WIDTH-1:0]  new_word,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [MEM_WIDTH-1:0] res;
    for (int i = 0; i < STRB_WIDTH; i++)
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ok      = ({1'b0, bus.WrAddr}  < DEPTH_LIM);
    rd_ok_a    = ({1'b0, bus.RdAddrA} < DEPTH_LIM);
    rd_ok_b    = ({1'b0, bus.RdAddrB} < DEPTH_LIM);
    wr_fire    = bus.WrEn && wr_ok;
    wr_old     = '0;
    rd_word_a  = '0;
    rd_word_b  = '0;

    if (wr_ok) wr_old = mem[bus.WrAddr];
    wr_word = merge_lanes(wr_old, bus.WrData, bus.WrStrb);

    // Write-first: a read hitting the address being written sees the merged word.
    if (rd_ok_a)
      rd_word_a = (wr_fire && bus.RdAddrA == bus.WrAddr) ? wr_word : mem[bus.RdAddrA];
    if (rd_ok_b)
      rd_word_b = (wr_fire && bus.RdAddrB == bus.WrAddr) ? wr_word : mem[bus.RdAddrB];

    addr_err_d = (bus.WrEn  && !wr_ok)
               | (bus.RdEnA && !rd_ok_a)
               | (bus.RdEnB && !rd_ok_b);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: storage is flop-based and must read back zero after reset, so every entry is cleared.
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      bus.RdDataA  <= '0;
      bus.RdDataB  <= '0;
      bus.RdValidA <= 1'b0;
      bus.RdValidB <= 1'b0;
      bus.AddrErr  <= 1'b0;
    end else begin
      // A zero strobe rewrites the old word, which is the required no-op.
      if (wr_fire) mem[bus.WrAddr] <= wr_word;

      if (bus.RdEnA) bus.RdDataA <= rd_word_a;
      if (bus.RdEnB) bus.RdDataB <= rd_word_b;
      bus.RdValidA <= bus.RdEnA;
      bus.RdValidB <= bus.RdEnB;
      bus.AddrErr  <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: a default 8-entry instance and a 6-entry
// instance for out-of-range behaviour, sharing clock and reset.
module tb_regfile_2r1w;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  regfile_2r1w_if #(.ADDR_WIDTH(3), .MEM_WIDTH(16)) b8 ();
  regfile_2r1w_if #(.ADDR_WIDTH(3), .MEM_WIDTH(16)) b6 ();

  regfile_2r1w #(.MEM_DEPTH(8), .MEM_WIDTH(16), .ADDR_WIDTH(3)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (b8)
  );

  regfile_2r1w #(.MEM_DEPTH(6), .MEM_WIDTH(16), .ADDR_WIDTH(3)) dut6 (
    .CLK (CLK),
    .RST (RST),
    .bus (b6)
  );

  task automatic idle();
    b8.WrEn = 0; b8.WrAddr = 0; b8.WrData = 0; b8.WrStrb = 0;
    b8.RdEnA = 0; b8.RdAddrA = 0; b8.RdEnB = 0; b8.RdAddrB = 0;
    b6.WrEn = 0; b6.WrAddr = 0; b6.WrData = 0; b6.WrStrb = 0;
    b6.RdEnA = 0; b6.RdAddrA = 0; b6.RdEnB = 0; b6.RdAddrB = 0;
  endtask

  // Inputs set before step() are sampled at its edge; outputs read after it
  // are the registered result of that edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 0;
    idle();
    step();
    step();
    n_cmp++;
    if (b8.RdDataA !== 16'h0 || b8.RdDataB !== 16'h0) begin
      n_err++;
      $display("FAIL reset_data: A=%h B=%h want 0000/0000", b8.RdDataA, b8.RdDataB);
    end
    n_cmp++;
    if (b8.RdValidA !== 1'b0 || b8.RdValidB !== 1'b0 || b8.AddrErr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: vA=%b vB=%b err=%b want 0/0/0", b8.RdValidA, b8.RdValidB, b8.AddrErr);
    end
    RST = 1;
    for (int i = 0; i < 8; i++) begin
      b8.RdEnA = 1; b8.RdAddrA = 3'(i);
      b8.RdEnB = 1; b8.RdAddrB = 3'(7 - i);
      step();
      n_cmp++;
      if (b8.RdDataA !== 16'h0 || b8.RdValidA !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read_a[%0d]: data=%h v=%b want 0000/1", i, b8.RdDataA, b8.RdValidA);
      end
      n_cmp++;
      if (b8.RdDataB !== 16'h0 || b8.RdValidB !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read_b[%0d]: data=%h v=%b want 0000/1", 7 - i, b8.RdDataB, b8.RdValidB);
      end
      n_cmp++;
      if (b8.AddrErr !== 1'b0) begin
        n_err++;
        $display("FAIL reset_read_err[%0d]: got %b want 0", i, b8.AddrErr);
      end
    end
    idle();
    step();
    n_cmp++;
    if (b8.RdValidA !== 1'b0 || b8.RdValidB !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid_drop: vA=%b vB=%b want 0/0", b8.RdValidA, b8.RdValidB);
    end
  endtask

  task automatic test_strobe_write();
    idle();
    b8.WrEn = 1; b8.WrAddr = 3'd2; b8.WrData = 16'hA5C3; b8.WrStrb = 2'b11;
    step();
    b8.WrData = 16'h00FF; b8.WrStrb = 2'b01;
    step();
    idle();
    b8.RdEnA = 1; b8.RdAddrA = 3'd2;
    step();
    n_cmp++;
    if (b8.RdDataA !== 16'hA5FF || b8.RdValidA !== 1'b1) begin
      n_err++;
      $display("FAIL strobe_merge: data=%h v=%b want a5ff/1", b8.RdDataA, b8.RdValidA);
    end
    idle();
    b8.WrEn = 1; b8.WrAddr = 3'd2; b8.WrData = 16'hFFFF; b8.WrStrb = 2'b00;
    step();
    n_cmp++;
    if (b8.AddrErr !== 1'b0) begin
      n_err++;
      $display("FAIL zero_strobe_err: got %b want 0", b8.AddrErr);
    end
    idle();
    b8.RdEnB = 1; b8.RdAddrB = 3'd2;
    step();
    n_cmp++;
    if (b8.RdDataB !== 16'hA5FF) begin
      n_err++;
      $display("FAIL zero_strobe_noop: got %h want a5ff", b8.RdDataB);
    end
  endtask

  task automatic test_bypass();
    idle();
    b8.WrEn = 1; b8.WrAddr = 3'd5; b8.WrData = 16'hBEEF; b8.WrStrb = 2'b11;
    step();
    b8.WrData = 16'h1234; b8.WrStrb = 2'b10;
    b8.RdEnA = 1; b8.RdAddrA = 3'd5;
    b8.RdEnB = 1; b8.RdAddrB = 3'd5;
    step();
    n_cmp++;
    if (b8.RdDataA !== 16'h12EF || b8.RdValidA !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_a: data=%h v=%b want 12ef/1", b8.RdDataA, b8.RdValidA);
    end
    n_cmp++;
    if (b8.RdDataB !== 16'h12EF || b8.RdValidB !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_b: data=%h v=%b want 12ef/1", b8.RdDataB, b8.RdValidB);
    end
    idle();
    b8.RdEnA = 1; b8.RdAddrA = 3'd5;
    step();
    n_cmp++;
    if (b8.RdDataA !== 16'h12EF) begin
      n_err++;
      $display("FAIL bypass_stored: got %h want 12ef", b8.RdDataA);
    end
  endtask

  task automatic test_out_of_range();
    idle();
    b6.WrEn = 1; b6.WrAddr = 3'd5; b6.WrData = 16'h5555; b6.WrStrb = 2'b11;
    step();
    n_cmp++;
    if (b6.AddrErr !== 1'b0) begin
      n_err++;
      $display("FAIL oor_inrange_write_err: got %b want 0", b6.AddrErr);
    end
    b6.WrAddr = 3'd7; b6.WrData = 16'hFFFF;
    step();
    n_cmp++;
    if (b6.AddrErr !== 1'b1) begin
      n_err++;
      $display("FAIL oor_write_err: got %b want 1", b6.AddrErr);
    end
    idle();
    b6.RdEnB = 1; b6.RdAddrB = 3'd5;
    step();
    n_cmp++;
    if (b6.AddrErr !== 1'b0 || b6.RdDataB !== 16'h5555) begin
      n_err++;
      $display("FAIL oor_err_pulse: err=%b data=%h want 0/5555", b6.AddrErr, b6.RdDataB);
    end
    b6.RdAddrB = 3'd6;
    step();
    n_cmp++;
    if (b6.RdDataB !== 16'h0 || b6.RdValidB !== 1'b1 || b6.AddrErr !== 1'b1) begin
      n_err++;
      $display("FAIL oor_read: data=%h v=%b err=%b want 0000/1/1", b6.RdDataB, b6.RdValidB, b6.AddrErr);
    end
    idle();
    b6.RdEnA = 1; b6.RdAddrA = 3'd5;
    b6.RdEnB = 1; b6.RdAddrB = 3'd1;
    step();
    n_cmp++;
    if (b6.RdDataA !== 16'h5555 || b6.RdDataB !== 16'h0 || b6.AddrErr !== 1'b0) begin
      n_err++;
      $display("FAIL oor_storage: e5=%h e1=%h err=%b want 5555/0000/0", b6.RdDataA, b6.RdDataB, b6.AddrErr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [4];
    exp[0] = 16'h0F0F; exp[1] = 16'h1E1E; exp[2] = 16'hA5FF; exp[3] = 16'h3C3C;
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        b8.WrEn = 1; b8.WrAddr = 3'(i); b8.WrData = exp[i]; b8.WrStrb = 2'b11;
        step();
      end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      b8.RdEnA = 1; b8.RdAddrA = 3'(i);
      step();
      n_cmp++;
      if (b8.RdDataA !== exp[i] || b8.RdValidA !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_read[%0d]: data=%h v=%b want %h/1", i, b8.RdDataA, b8.RdValidA, exp[i]);
      end
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (b8.RdDataA !== 16'h3C3C || b8.RdValidA !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_hold[%0d]: data=%h v=%b want 3c3c/0", i, b8.RdDataA, b8.RdValidA);
      end
    end
  endtask

  task automatic test_bypass_split();
    idle();
    b8.WrEn = 1; b8.WrAddr = 3'd3; b8.WrData = 16'h00AA; b8.WrStrb = 2'b01;
    b8.RdEnA = 1; b8.RdAddrA = 3'd4;
    b8.RdEnB = 1; b8.RdAddrB = 3'd3;
    step();
    n_cmp++;
    if (b8.RdDataA !== 16'h0000 || b8.RdDataB !== 16'h3CAA) begin
      n_err++;
      $display("FAIL bypass_split: A=%h B=%h want 0000/3caa", b8.RdDataA, b8.RdDataB);
    end
  endtask

  task automatic test_reset_mid_op();
    idle();
    b8.WrEn = 1; b8.WrAddr = 3'd1; b8.WrData = 16'hDEAD; b8.WrStrb = 2'b11;
    b8.RdEnA = 1; b8.RdAddrA = 3'd1;
    RST = 0;
    step();
    RST = 1;
    idle();
    n_cmp++;
    if (b8.RdValidA !== 1'b0 || b8.RdDataA !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: v=%b data=%h want 0/0000", b8.RdValidA, b8.RdDataA);
    end
    step();
    n_cmp++;
    if (b8.RdValidA !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_no_pulse: got %b want 0", b8.RdValidA);
    end
    b8.RdEnA = 1; b8.RdAddrA = 3'd1;
    b8.RdEnB = 1; b8.RdAddrB = 3'd5;
    step();
    n_cmp++;
    if (b8.RdDataA !== 16'h0 || b8.RdDataB !== 16'h0 || b8.RdValidA !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_storage: e1=%h e5=%h v=%b want 0000/0000/1", b8.RdDataA, b8.RdDataB, b8.RdValidA);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_strobe_write();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    test_bypass_split();
    test_reset_mid_op();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
